debounce_edge: RTL and testbench

Debounced level and press-event generator for a single-bit external input such as a push-button or switch. It takes the registered raw input from the preceding D-flip-flop stage and resynchronises it. It then filters out bounce and glitches and produces a clean level, single-cycle rise/fall pulses, and short-press/long-press classification pulses for downstream control logic.

---
 rtl/debounce_edge.sv | 134 +++++++++++++
 tb/tb_debounce_edge.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/debounce_edge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | debounce_edge: resynchronised, debounced level with edge and press pulses |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module debounce_edge #(
  parameter int STABLE_CYCLES = 4,
  parameter int LONG_CYCLES   = 20,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall,
  output logic short_press,
  output logic long_press
);

  localparam logic [CNT_W-1:0] c_STABLE_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_LONG_MAX   = CNT_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_HELD  = 2'd2
  } state_t;

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_scnt;
  logic [CNT_W-1:0] r_hcnt;
  state_t           r_state;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_hcnt_nxt;
  logic             w_short_nxt;
  logic             w_long_nxt;
  logic             w_differs;
  logic             w_at_thresh;
  logic             w_rise_dec;
  logic             w_fall_dec;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= din;
      r_s2 <= r_s1;
    end
  end

  // A change is committed once s2 has disagreed with level for STABLE_CYCLES edges.
  assign w_differs   = (r_s2 != level);
  assign w_at_thresh = w_differs && (r_scnt == c_STABLE_MAX);
  assign w_rise_dec  = w_at_thresh && r_s2;
  assign w_fall_dec  = w_at_thresh && !r_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scnt <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= w_rise_dec;
      fall <= w_fall_dec;
      if (!w_differs || w_at_thresh) begin
        r_scnt <= '0;
      end else begin
        r_scnt <= r_scnt + 1'b1;
      end
      if (w_at_thresh) begin
        level <= r_s2;
      end
    end
  end

  // Fall decision is checked before the long threshold so a coincident release counts as short.
  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_short_nxt = 1'b0;
    w_long_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise_dec) begin
          w_state_nxt = ST_PRESS;
          w_hcnt_nxt  = '0;
        end
      end
      ST_PRESS: begin
        if (w_fall_dec) begin
          w_state_nxt = ST_IDLE;
          w_hcnt_nxt  = '0;
          w_short_nxt = 1'b1;
        end else if (r_hcnt == c_LONG_MAX) begin
          w_state_nxt = ST_HELD;
          w_long_nxt  = 1'b1;
        end else begin
          w_hcnt_nxt  = r_hcnt + 1'b1;
        end
      end
      ST_HELD: begin
        if (w_fall_dec) begin
          w_state_nxt = ST_IDLE;
          w_hcnt_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_hcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_hcnt      <= '0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hcnt      <= w_hcnt_nxt;
      short_press <= w_short_nxt;
      long_press  <= w_long_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_debounce_edge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_debounce_edge: scoreboard bench for debounce_edge (defaults 4 / 20)    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_debounce_edge;

  logic clk = 1'b0;
  logic reset;
  logic din;
  logic level, rise, fall, short_press, long_press;

  debounce_edge #(
    .STABLE_CYCLES(4),
    .LONG_CYCLES  (20),
    .CNT_W        (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .level      (level),
    .rise       (rise),
    .fall       (fall),
    .short_press(short_press),
    .long_press (long_press)
  );

  always #5 clk = ~clk;

  // Posedge counter: at a negedge it equals the index of the last rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] pulses;  // {rise, fall, short_press, long_press}
    logic       lvl;
  } ev_t;

  ev_t q[$];
  int  errors = 0;
  int  checks = 0;

  localparam logic [3:0] P_RISE       = 4'b1000;
  localparam logic [3:0] P_FALL_SHORT = 4'b0110;
  localparam logic [3:0] P_FALL       = 4'b0100;
  localparam logic [3:0] P_LONG       = 4'b0001;

  task automatic expect_ev(input int c, input logic [3:0] p, input logic l);
    ev_t e;
    e.cyc    = c;
    e.pulses = p;
    e.lvl    = l;
    q.push_back(e);
  endtask

  // Called at a negedge; returns the index of the first edge that samples v.
  task automatic set_din(input logic v, output int e0);
    din = v;
    e0  = cyc + 1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({level, rise, fall, short_press, long_press} != 5'b0) begin
      errors++;
      $display("FAIL %s: outputs {level,rise,fall,short,long}=%b required 00000", name,
               {level, rise, fall, short_press, long_press});
    end
  endtask

  task automatic check_level(input string name, input logic l);
    checks++;
    if (level !== l) begin
      errors++;
      $display("FAIL %s: level=%b required %b", name, level, l);
    end
  endtask

  // Monitor: pops one expected event per observed pulse cycle, flags missed events.
  ev_t        mon_e;
  logic [3:0] mon_p;
  always @(negedge clk) begin
    mon_p = {rise, fall, short_press, long_press};
    if (mon_p != 4'b0) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: cyc=%0d pulses=%b required none", cyc, mon_p);
      end else begin
        mon_e = q.pop_front();
        checks++;
        if (cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL event_time: cyc=%0d required %0d (pulses=%b)", cyc, mon_e.cyc, mon_p);
        end
        checks++;
        if (mon_p != mon_e.pulses) begin
          errors++;
          $display("FAIL event_pulses: cyc=%0d pulses=%b required %b", cyc, mon_p, mon_e.pulses);
        end
        checks++;
        if (level !== mon_e.lvl) begin
          errors++;
          $display("FAIL event_level: cyc=%0d level=%b required %b", cyc, level, mon_e.lvl);
        end
      end
    end else if (q.size() != 0 && q[0].cyc < cyc) begin
      mon_e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_event: cyc=%0d pulses=0000 required %b at cyc %0d",
               cyc, mon_e.pulses, mon_e.cyc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d required 0", q.size());
    $fatal(1, "watchdog expired");
  end

  int a, f, r0;

  initial begin
    reset = 1'b1;
    din   = 1'b0;
    wait_cyc(3);
    check_zero("reset_outputs");
    reset = 1'b0;

    // Idle with din low: no activity allowed.
    wait_cyc(10);
    check_zero("idle_after_reset");

    // Short press: 15 high samples.
    set_din(1'b1, a);
    expect_ev(a + 5, P_RISE, 1'b1);
    wait_cyc(15);
    check_level("short_press_level_high", 1'b1);
    set_din(1'b0, f);
    expect_ev(f + 5, P_FALL_SHORT, 1'b0);
    wait_cyc(12);
    check_level("short_press_level_low", 1'b0);

    // Glitch of 3 samples: rejected.
    set_din(1'b1, a);
    wait_cyc(3);
    set_din(1'b0, f);
    wait_cyc(10);
    check_level("glitch_level", 1'b0);

    // Bounce every 2 cycles, then settle high.
    for (int i = 0; i < 6; i++) begin
      set_din((i % 2) == 0, a);
      wait_cyc(2);
    end
    set_din(1'b1, a);
    expect_ev(a + 5, P_RISE, 1'b1);
    wait_cyc(10);
    set_din(1'b0, f);
    expect_ev(f + 5, P_FALL_SHORT, 1'b0);
    wait_cyc(12);

    // Long press: 40 high samples.
    set_din(1'b1, a);
    expect_ev(a + 5,  P_RISE, 1'b1);
    expect_ev(a + 25, P_LONG, 1'b1);
    wait_cyc(40);
    set_din(1'b0, f);
    expect_ev(f + 5, P_FALL, 1'b0);
    wait_cyc(12);

    // Reset while HELD, din stays high; fresh rise after release.
    set_din(1'b1, a);
    expect_ev(a + 5,  P_RISE, 1'b1);
    expect_ev(a + 25, P_LONG, 1'b1);
    wait_cyc(30);
    check_level("held_level", 1'b1);
    reset = 1'b1;
    #1;
    check_zero("reset_mid_press");
    wait_cyc(3);
    check_zero("reset_held_low");
    reset = 1'b0;
    r0 = cyc + 1;
    expect_ev(r0 + 5, P_RISE, 1'b1);
    wait_cyc(10);
    set_din(1'b0, f);
    expect_ev(f + 5, P_FALL_SHORT, 1'b0);
    wait_cyc(12);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending events=%0d required 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
